// File: rtl/de10_debounced_key_pio.sv
// Avalon-MM input port: per-bit synchroniser, programmable-period debounce,
// rise/fall edge capture (W1C) and masked level interrupt.
module de10_debounced_key_pio #(
    parameter int unsigned       WIDTH           = 4,
    parameter int unsigned       SYNC_STAGES     = 2,
    parameter int unsigned       CNT_W           = 20,
    parameter int unsigned       DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0]  RESET_LEVEL     = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    typedef enum logic [2:0] {
        A_DATA   = 3'd0,
        A_RAW    = 3'd1,
        A_MASK   = 3'd2,
        A_EDGE   = 3'd3,
        A_RISE   = 3'd4,
        A_FALL   = 3'd5,
        A_PERIOD = 3'd6,
        A_NONE   = 3'd7
    } reg_addr_e;

    reg_addr_e        addr;
    logic             wr;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_q;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [CNT_W-1:0] period;
    logic [CNT_W:0]   p_eff;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      rd_mux;
    logic             unused_writedata;

    assign addr  = reg_addr_e'(address);
    assign wr    = chipselect & ~write_n;
    assign sync  = sync_q[SYNC_STAGES-1];
    // Period 0 behaves as 1; one extra bit keeps cnt+1 from wrapping in the compare.
    assign p_eff = (period == '0) ? (CNT_W+1)'(1) : {1'b0, period};

    assign rise = ~stable_q & stable & rise_en;
    assign fall = stable_q & ~stable & fall_en;
    assign w1c  = (wr && addr == A_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign irq  = |(edge_cap & irq_mask);

    assign unused_writedata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RESET_LEVEL;
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable   <= RESET_LEVEL;
            stable_q <= RESET_LEVEL;
            for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            stable_q <= stable;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (({1'b0, cnt[i]} + (CNT_W+1)'(1)) >= p_eff) begin
                    stable[i] <= sync[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
            edge_cap <= '0;
            rise_en  <= '0;
            fall_en  <= '1;
            period   <= CNT_W'(DEBOUNCE_CYCLES);
            readdata <= '0;
        end else begin
            // New edges are OR-ed in after the clear so a colliding W1C loses.
            edge_cap <= (edge_cap & ~w1c) | rise | fall;
            if (wr) begin
                case (addr)
                    A_MASK:   irq_mask <= writedata[WIDTH-1:0];
                    A_RISE:   rise_en  <= writedata[WIDTH-1:0];
                    A_FALL:   fall_en  <= writedata[WIDTH-1:0];
                    A_PERIOD: period   <= writedata[CNT_W-1:0];
                    default:  ;
                endcase
            end
            readdata <= rd_mux;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            A_DATA:   rd_mux[WIDTH-1:0] = stable;
            A_RAW:    rd_mux[WIDTH-1:0] = sync;
            A_MASK:   rd_mux[WIDTH-1:0] = irq_mask;
            A_EDGE:   rd_mux[WIDTH-1:0] = edge_cap;
            A_RISE:   rd_mux[WIDTH-1:0] = rise_en;
            A_FALL:   rd_mux[WIDTH-1:0] = fall_en;
            A_PERIOD: rd_mux[CNT_W-1:0] = period;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_de10_debounced_key_pio.sv
// Directed, table-driven bench for de10_debounced_key_pio (WIDTH=4, 2 sync stages).
module tb_de10_debounced_key_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [3:0]  in_port = 4'hF;
    logic [31:0] readdata;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        wr;
        logic        cs;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    de10_debounced_key_pio #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .CNT_W(20),
        .DEBOUNCE_CYCLES(500000),
        .RESET_LEVEL(4'hF)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic cs);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        @(negedge clk);
        check(name, readdata, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic seen_low;
        int   rises;
        logic prev_irq;

        tbl.push_back('{1'b0, 1'b0, 3'd0, 32'h0,        32'hF,     "rst_data"});
        tbl.push_back('{1'b0, 1'b0, 3'd1, 32'h0,        32'hF,     "rst_raw"});
        tbl.push_back('{1'b0, 1'b0, 3'd2, 32'h0,        32'h0,     "rst_mask"});
        tbl.push_back('{1'b0, 1'b0, 3'd3, 32'h0,        32'h0,     "rst_edge"});
        tbl.push_back('{1'b0, 1'b0, 3'd4, 32'h0,        32'h0,     "rst_rise"});
        tbl.push_back('{1'b0, 1'b0, 3'd5, 32'h0,        32'hF,     "rst_fall"});
        tbl.push_back('{1'b0, 1'b0, 3'd6, 32'h0,        32'd500000,"rst_period"});
        tbl.push_back('{1'b0, 1'b0, 3'd7, 32'h0,        32'h0,     "rst_unmapped"});
        tbl.push_back('{1'b1, 1'b1, 3'd2, 32'hFFFFFFFF, 32'h0,     ""});
        tbl.push_back('{1'b0, 1'b0, 3'd2, 32'h0,        32'hF,     "mask_trunc"});
        tbl.push_back('{1'b1, 1'b1, 3'd4, 32'h0000005A, 32'h0,     ""});
        tbl.push_back('{1'b0, 1'b0, 3'd4, 32'h0,        32'hA,     "rise_rw"});
        tbl.push_back('{1'b1, 1'b1, 3'd6, 32'hFFFFFFFF, 32'h0,     ""});
        tbl.push_back('{1'b0, 1'b0, 3'd6, 32'h0,        32'hFFFFF, "period_trunc"});
        tbl.push_back('{1'b1, 1'b1, 3'd7, 32'h00001234, 32'h0,     ""});
        tbl.push_back('{1'b0, 1'b0, 3'd7, 32'h0,        32'h0,     "unmapped_wr"});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 32'h00000000, 32'h0,     ""});
        tbl.push_back('{1'b0, 1'b0, 3'd0, 32'h0,        32'hF,     "data_ro"});
        tbl.push_back('{1'b1, 1'b1, 3'd3, 32'h0000000F, 32'h0,     ""});
        tbl.push_back('{1'b0, 1'b0, 3'd3, 32'h0,        32'h0,     "edge_w1c_empty"});
        tbl.push_back('{1'b1, 1'b0, 3'd2, 32'h00000000, 32'h0,     ""});
        tbl.push_back('{1'b0, 1'b0, 3'd2, 32'h0,        32'hF,     "no_cs_write"});
        tbl.push_back('{1'b1, 1'b1, 3'd2, 32'h00000000, 32'h0,     ""});
        tbl.push_back('{1'b1, 1'b1, 3'd4, 32'h00000000, 32'h0,     ""});
        tbl.push_back('{1'b1, 1'b1, 3'd6, 32'h00000004, 32'h0,     ""});
        tbl.push_back('{1'b0, 1'b0, 3'd6, 32'h0,        32'h4,     "period_4"});

        // Reset state
        idle(3);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        idle(4);

        foreach (tbl[i]) begin
            if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data, tbl[i].cs);
            else           read_check(tbl[i].name, tbl[i].addr, tbl[i].exp);
        end

        // Fall on bit 0 with P=4: irq exactly 7 cycles after the input edge
        bus_write(3'd2, 32'h1, 1'b1);
        in_port[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("irq_latency_c%0d", k), {31'b0, irq}, (k == 7) ? 32'h1 : 32'h0);
        end
        read_check("edge_bit0", 3'd3, 32'h1);
        read_check("data_bit0", 3'd0, 32'hE);
        bus_write(3'd3, 32'h1, 1'b1);
        check("irq_w1c_drop", {31'b0, irq}, 32'h0);
        in_port[0] = 1'b1;
        idle(10);
        read_check("rise_disabled", 3'd3, 32'h0);

        // 5-cycle pulse passes, 3-cycle pulse is filtered
        address  = 3'd0;
        seen_low = 1'b0;
        in_port[1] = 1'b0;
        for (int k = 0; k < 18; k++) begin
            if (k == 5) in_port[1] = 1'b1;
            @(negedge clk);
            if (!readdata[1]) seen_low = 1'b1;
        end
        check("pulse5_data", {31'b0, seen_low}, 32'h1);
        read_check("pulse5_edge", 3'd3, 32'h2);
        bus_write(3'd3, 32'hF, 1'b1);
        address  = 3'd0;
        seen_low = 1'b0;
        in_port[1] = 1'b0;
        for (int k = 0; k < 18; k++) begin
            if (k == 3) in_port[1] = 1'b1;
            @(negedge clk);
            if (!readdata[1]) seen_low = 1'b1;
        end
        check("pulse3_data", {31'b0, seen_low}, 32'h0);
        read_check("pulse3_edge", 3'd3, 32'h0);

        // Rise-only on bit 2; RAW follows input two cycles later (+1 read latency)
        bus_write(3'd4, 32'h4, 1'b1);
        bus_write(3'd5, 32'h0, 1'b1);
        address = 3'd1;
        in_port[2] = 1'b0;
        idle(2);
        check("raw_press_c2", readdata, 32'hF);
        idle(1);
        check("raw_press_c3", readdata, 32'hB);
        idle(8);
        read_check("press_no_cap", 3'd3, 32'h0);
        read_check("press_data", 3'd0, 32'hB);
        address = 3'd1;
        in_port[2] = 1'b1;
        idle(2);
        check("raw_rel_c2", readdata, 32'hB);
        idle(1);
        check("raw_rel_c3", readdata, 32'hF);
        idle(8);
        read_check("release_cap", 3'd3, 32'h4);
        read_check("release_data", 3'd0, 32'hF);

        // W1C of bit 3 on the same edge its capture sets: set wins
        bus_write(3'd4, 32'h0, 1'b1);
        bus_write(3'd5, 32'h8, 1'b1);
        bus_write(3'd3, 32'hF, 1'b1);
        in_port[3] = 1'b0;
        idle(6);
        bus_write(3'd3, 32'h8, 1'b1);
        read_check("collision_set_wins", 3'd3, 32'h8);
        bus_write(3'd3, 32'h8, 1'b1);
        read_check("w1c_after_collision", 3'd3, 32'h0);
        in_port[3] = 1'b1;
        idle(10);

        // Reset mid-count with bit 0 held low
        bus_write(3'd5, 32'hF, 1'b1);
        in_port[0] = 1'b0;
        idle(4);
        reset_n = 1'b0;
        idle(2);
        check("midrst_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        idle(20);
        read_check("held_no_cap", 3'd3, 32'h0);
        read_check("held_data", 3'd0, 32'hF);
        check("held_irq", {31'b0, irq}, 32'h0);
        in_port[0] = 1'b1;
        idle(5);
        bus_write(3'd6, 32'h4, 1'b1);
        bus_write(3'd2, 32'h1, 1'b1);
        rises    = 0;
        prev_irq = irq;
        in_port[0] = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (k == 12) in_port[0] = 1'b1;
            @(negedge clk);
            if (irq && !prev_irq) rises++;
            prev_irq = irq;
        end
        check("repress_irq_rises", rises, 32'd1);
        read_check("repress_cap", 3'd3, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
